keypad_scan_4x4: RTL and testbench

Sequential front end for the 16-key input path. Scans a 4x4 active-low matrix keypad one column at a time and debounces the result over whole scans. Emits a stable 16-bit one-hot key vector, which feeds directly into the 16-to-4 one-hot encoder stage downstream. Also provides key-down and new-key strobes for the control logic.

---
 rtl/keypad_scan_4x4_pkg.sv | 29 ++
 rtl/keypad_debounce.sv | 71 +++++++
 rtl/keypad_scan_4x4.sv | 127 ++++++++++++
 tb/tb_keypad_scan_4x4.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_4x4_pkg.sv
// Shared definitions for the 4x4 keypad scanner: geometry, scan state
// encoding, column drive table and a one-hot test helper.
package keypad_scan_4x4_pkg;

  localparam int unsigned KEY_N = 16;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;

  typedef enum logic {
    S_COL  = 1'b0,
    S_EVAL = 1'b1
  } scan_state_e;

  // Column drive patterns indexed by column; entry 4 is the idle (all high) drive.
  localparam int unsigned COL_IDLE_IDX = 4;
  localparam logic [4:0][3:0] COL_DRIVE = {
    4'b1111,  // idle
    4'b0111,  // column 3
    4'b1011,  // column 2
    4'b1101,  // column 1
    4'b1110   // column 0
  };

  // True when exactly one bit of a 16-bit key vector is set.
  function automatic logic is_onehot16(input logic [KEY_N-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: a candidate key vector must repeat on
// DEBOUNCE_SCANS consecutive evaluations before it reaches the output.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   eval        - one-cycle strobe, candidate is valid
//   candidate   - 16-bit key vector from the current scan (0 or one-hot)
//   onehot      - debounced key vector
//   key_down    - high while onehot is non-zero
//   key_valid   - one-cycle strobe when onehot takes a new non-zero value
module keypad_debounce
  import keypad_scan_4x4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eval,
  input  logic [KEY_N-1:0] candidate,
  output logic [KEY_N-1:0] onehot,
  output logic             key_down,
  output logic             key_valid
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [KEY_N-1:0] prev_cand;
  logic [KEY_N-1:0] prev_cand_nxt;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_cnt_nxt;
  logic [KEY_N-1:0] onehot_nxt;
  logic             key_valid_nxt;

  // Compare against the previous candidate and run the saturating count.
  always_comb begin
    prev_cand_nxt  = prev_cand;
    stable_cnt_nxt = stable_cnt;
    onehot_nxt     = onehot;
    key_valid_nxt  = 1'b0;
    if (eval) begin
      if (candidate == prev_cand) begin
        stable_cnt_nxt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
      end else begin
        prev_cand_nxt  = candidate;
        stable_cnt_nxt = CNT_W'(1);
      end
      // The count used here already includes this scan.
      if ((stable_cnt_nxt == CNT_MAX) && (candidate != onehot)) begin
        onehot_nxt    = candidate;
        key_valid_nxt = |candidate;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cand  <= '0;
      stable_cnt <= '0;
      onehot     <= '0;
      key_down   <= 1'b0;
      key_valid  <= 1'b0;
    end else begin
      prev_cand  <= prev_cand_nxt;
      stable_cnt <= stable_cnt_nxt;
      onehot     <= onehot_nxt;
      key_down   <= |onehot_nxt;
      key_valid  <= key_valid_nxt;
    end
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low matrix keypad scanner. Drives one column low at a time for
// SCAN_DIV cycles, snapshots the synchronised rows at the end of each slot,
// and after the fourth column spends one idle cycle evaluating the scan.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   row_n      - keypad rows, active low, asynchronous to clk
//   col_n      - column drive, active low, at most one bit low
//   onehot     - debounced key vector, bit 4*row+col
//   key_down   - high while onehot is non-zero
//   key_valid  - one-cycle strobe on a new non-zero onehot value
module keypad_scan_4x4
  import keypad_scan_4x4_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_N-1:0] onehot,
  output logic             key_down,
  output logic             key_valid
);

  localparam int unsigned      SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [ROWS-1:0]   row_meta;
  logic [ROWS-1:0]   row_sync;

  scan_state_e       state;
  scan_state_e       state_nxt;
  logic [1:0]        col_idx;
  logic [1:0]        col_idx_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_cnt_nxt;
  logic [KEY_N-1:0]  snapshot;
  logic [KEY_N-1:0]  snapshot_nxt;
  logic [COLS-1:0]   col_n_nxt;

  logic              eval_c;
  logic [KEY_N-1:0]  candidate_c;

  // Two-flop synchroniser; idle rows read as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_COL;
      col_idx  <= '0;
      slot_cnt <= '0;
      snapshot <= '0;
      col_n    <= COL_DRIVE[3'd0];
    end else begin
      state    <= state_nxt;
      col_idx  <= col_idx_nxt;
      slot_cnt <= slot_cnt_nxt;
      snapshot <= snapshot_nxt;
      col_n    <= col_n_nxt;
    end
  end

  // Next-state logic; col_n is registered, so it is driven from the next column.
  always_comb begin
    state_nxt    = state;
    col_idx_nxt  = col_idx;
    slot_cnt_nxt = slot_cnt;
    snapshot_nxt = snapshot;
    col_n_nxt    = col_n;
    eval_c       = 1'b0;
    candidate_c  = '0;
    unique case (state)
      S_COL: begin
        if (slot_cnt == SLOT_LAST) begin
          // Key (r, col_idx) lives at bit 4*r+col_idx = {r, col_idx}.
          for (int unsigned r = 0; r < ROWS; r++) begin
            snapshot_nxt[{2'(r), col_idx}] = ~row_sync[r];
          end
          slot_cnt_nxt = '0;
          if (col_idx == 2'd3) begin
            state_nxt = S_EVAL;
            col_n_nxt = COL_DRIVE[3'(COL_IDLE_IDX)];
          end else begin
            col_idx_nxt = col_idx + 2'd1;
            col_n_nxt   = COL_DRIVE[{1'b0, col_idx_nxt}];
          end
        end else begin
          slot_cnt_nxt = slot_cnt + SLOT_W'(1);
        end
      end
      S_EVAL: begin
        // Multi-press and ghost patterns collapse to "no key".
        eval_c       = 1'b1;
        candidate_c  = is_onehot16(snapshot) ? snapshot : '0;
        state_nxt    = S_COL;
        col_idx_nxt  = '0;
        slot_cnt_nxt = '0;
        snapshot_nxt = '0;
        col_n_nxt    = COL_DRIVE[3'd0];
      end
      default: state_nxt = S_COL;
    endcase
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .eval      (eval_c),
    .candidate (candidate_c),
    .onehot    (onehot),
    .key_down  (key_down),
    .key_valid (key_valid)
  );

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A physical keypad model turns the pressed-key mask into row levels; a
// scan-level reference model predicts col_n and the debounced outputs.
module tb_keypad_scan_4x4;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned PERIOD   = 4 * SCAN_DIV + 1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] onehot;
  logic        key_down;
  logic        key_valid;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_strobes = 0;

  // Reference model state.
  int          ph;
  logic [15:0] snap;
  logic [15:0] exp_onehot;
  logic        exp_valid;
  logic [15:0] hist[$];

  logic [3:0] col_seq [17] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                               4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF};

  always #5 clk = ~clk;

  keypad_scan_4x4 #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .onehot    (onehot),
    .key_down  (key_down),
    .key_valid (key_valid)
  );

  // Keypad: a row reads low when any pressed key in it sits on a driven-low column.
  assign row_n = {~|(pressed[15:12] & ~col_n), ~|(pressed[11:8] & ~col_n),
                  ~|(pressed[7:4] & ~col_n),   ~|(pressed[3:0] & ~col_n)};

  function automatic logic [3:0] exp_col(input int p);
    logic [3:0] one;
    one = 4'b0001;
    if (p == 16) return 4'b1111;
    return ~(one << (p / 4));
  endfunction

  task automatic model_reset();
    ph         = 0;
    snap       = '0;
    exp_onehot = '0;
    exp_valid  = 1'b0;
    hist.delete();
  endtask

  // Advance the model by the cycle whose phase was ph.
  task automatic model_step();
    logic [15:0] cand;
    logic        same;
    int          c;
    exp_valid = 1'b0;
    if (ph < 16 && (ph % 4) == 1) begin
      // Rows seen by the sampling flop are those of slot 1 (two-flop delay to slot 3).
      c = ph / 4;
      for (int r = 0; r < 4; r++) snap[4*r + c] = pressed[4*r + c];
    end
    if (ph == 16) begin
      cand = ($countones(snap) == 1) ? snap : 16'h0000;
      hist.push_back(cand);
      if (hist.size() > DEB) void'(hist.pop_front());
      same = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] != cand) same = 1'b0;
      if (same && cand != exp_onehot) begin
        exp_valid  = (cand != 16'h0000);
        exp_onehot = cand;
      end
      snap = '0;
      ph   = 0;
    end else begin
      ph = ph + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) n_strobes++;
      check("cyc_col_n",     16'(col_n),     16'(exp_col(ph)));
      check("cyc_onehot",    onehot,         exp_onehot);
      check("cyc_key_down",  16'(key_down),  16'(|exp_onehot));
      check("cyc_key_valid", 16'(key_valid), 16'(exp_valid));
    end
  endtask

  task automatic sync_scan();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ph == 0) return;
    end
    check("scan_align_timeout", 16'(ph), 16'h0000);
  endtask

  // Hold a key mask for n whole scans, starting and ending on a phase-0 negedge.
  task automatic drive_scans(input logic [15:0] mask, input int n);
    pressed = mask;
    repeat (PERIOD * n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"},     16'(col_n),     16'h000E);
    check({tag, "_onehot"},    onehot,         16'h0000);
    check({tag, "_key_down"},  16'(key_down),  16'h0000);
    check({tag, "_key_valid"}, 16'(key_valid), 16'h0000);
  endtask

  initial begin
    int s0;
    logic [15:0] cur;
    fork
      compare_loop();
    join_none

    // Reset held for five cycles.
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Two full scans of column drive.
    for (int i = 0; i < 2 * int'(PERIOD); i++) begin
      @(negedge clk);
      check("seq_col_n", 16'(col_n), 16'(col_seq[i % 17]));
    end

    sync_scan();

    // Clean press row 2 / col 1.
    s0 = n_strobes;
    drive_scans(16'h0200, 2);
    check("press_early", onehot, 16'h0000);
    drive_scans(16'h0200, 1);
    check("press_onehot", onehot, 16'h0200);
    drive_scans(16'h0200, 1);
    check("press_strobes", 16'(n_strobes - s0), 16'h0001);
    check("press_key_down", 16'(key_down), 16'h0001);

    // Release, then ghost pair: no strobes, output clears.
    s0 = n_strobes;
    drive_scans(16'h0000, 2);
    check("release_early", onehot, 16'h0200);
    drive_scans(16'h0000, 1);
    check("release_onehot", onehot, 16'h0000);
    check("release_key_down", 16'(key_down), 16'h0000);
    drive_scans(16'h8001, 4);
    check("ghost_onehot", onehot, 16'h0000);
    check("release_ghost_strobes", 16'(n_strobes - s0), 16'h0000);

    // Bounce on row 0 / col 3: present, present, absent, then three present.
    s0 = n_strobes;
    drive_scans(16'h0008, 2);
    drive_scans(16'h0000, 1);
    drive_scans(16'h0008, 2);
    check("bounce_early", onehot, 16'h0000);
    drive_scans(16'h0008, 1);
    check("bounce_onehot", onehot, 16'h0008);

    // Direct key-to-key change.
    drive_scans(16'h0001, 3);
    check("change_first", onehot, 16'h0001);
    drive_scans(16'h0001, 1);
    check("bounce_change_strobes", 16'(n_strobes - s0), 16'h0002);
    s0 = n_strobes;
    drive_scans(16'h8000, 3);
    check("change_second", onehot, 16'h8000);
    drive_scans(16'h8000, 1);
    check("change_strobes", 16'(n_strobes - s0), 16'h0001);

    // Reset mid-slot while a new key is being counted.
    drive_scans(16'h0010, 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    pressed = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_seq_col_n", 16'(col_n), 16'(col_seq[i]));
    end

    // Randomised key traffic with occasional mid-scan glitches.
    sync_scan();
    cur = '0;
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 9))
        6, 7:    cur = 16'h0001 << $urandom_range(0, 15);
        8:       cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        9:       cur = 16'h0000;
        default: ;
      endcase
      for (int j = 0; j < int'(PERIOD); j++) begin
        if ($urandom_range(0, 19) == 0) pressed = 16'($urandom);
        else                            pressed = cur;
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1);
  end

endmodule
